// File: rtl/oam_dma.sv
// oam_dma: CPU-side writer into sprite attribute memory (OAM).
// Decodes OAMADDR ($2003), OAMDATA ($2004) and the DMA trigger register.
// A DMA write halts the CPU and copies one 256-byte page of main memory into
// OAM, taking 513 CPU cycles when triggered on an even cycle and 514 on an odd one.
//
// Bus protocol: every register and state update is qualified by ce_cpu, which
// pulses for one clock25 cycle per CPU cycle. A CPU write is accepted on a
// ce_cpu tick with cpu_w=1. Memory data on mem_i is sampled on the ce_cpu tick
// that follows the tick in which dma_a/dma_rd were registered. oam_w is a
// single clock25 pulse and never waits for acknowledgement.
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter int          OAM_SIZE = 256
) (
  input  logic        clock25,
  input  logic        reset,
  input  logic        ce_cpu,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_o,
  input  logic        cpu_w,
  input  logic [7:0]  mem_i,
  output logic        halt,
  output logic [15:0] dma_a,
  output logic        dma_rd,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_d,
  output logic        oam_w,
  output logic [7:0]  oamaddr,
  output logic [2:0]  dbg_state
);

  // Index of the last byte of a DMA copy.
  localparam logic [7:0] LAST_IDX = 8'(OAM_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_halt,    w_halt_next;
  logic [15:0] r_dma_a,   w_dma_a_next;
  logic        r_dma_rd,  w_dma_rd_next;
  logic [7:0]  r_oam_a,   w_oam_a_next;
  logic [7:0]  r_oam_d,   w_oam_d_next;
  logic        r_oam_w,   w_oam_w_next;
  logic [7:0]  r_oamaddr, w_oamaddr_next;
  logic [7:0]  r_page,    w_page_next;
  logic [7:0]  r_idx,     w_idx_next;
  logic        r_cyc,     w_cyc_next;
  logic        r_par,     w_par_next;

  // PPU register window: $2000-$3FFF, mirrored every 8 bytes.
  logic w_ppu_sel;
  logic w_wr_oamaddr;
  logic w_wr_oamdata;
  logic w_wr_dma;

  assign w_ppu_sel    = (cpu_a[15:13] == 3'b001);
  assign w_wr_oamaddr = cpu_w && w_ppu_sel && (cpu_a[2:0] == 3'd3);
  assign w_wr_oamdata = cpu_w && w_ppu_sel && (cpu_a[2:0] == 3'd4);
  assign w_wr_dma     = cpu_w && (cpu_a == DMA_REG);

  // State register; reset wins over a simultaneous ce_cpu tick.
  always_ff @(posedge clock25) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and datapath decisions; nothing moves without ce_cpu except
  // the oam_w pulse, which self-clears on the following clock.
  always_comb begin
    w_state_next   = r_state;
    w_halt_next    = r_halt;
    w_dma_a_next   = r_dma_a;
    w_dma_rd_next  = r_dma_rd;
    w_oam_a_next   = r_oam_a;
    w_oam_d_next   = r_oam_d;
    w_oam_w_next   = 1'b0;
    w_oamaddr_next = r_oamaddr;
    w_page_next    = r_page;
    w_idx_next     = r_idx;
    w_cyc_next     = r_cyc;
    w_par_next     = r_par;

    if (ce_cpu) begin
      w_cyc_next = ~r_cyc;
      case (r_state)
        S_IDLE: begin
          if (w_wr_dma) begin
            // Parity captured before this tick's toggle decides the alignment cycle.
            w_page_next  = cpu_o;
            w_idx_next   = 8'd0;
            w_par_next   = r_cyc;
            w_halt_next  = 1'b1;
            w_state_next = S_WAIT;
          end else if (w_wr_oamaddr) begin
            w_oamaddr_next = cpu_o;
          end else if (w_wr_oamdata) begin
            w_oam_a_next   = r_oamaddr;
            w_oam_d_next   = cpu_o;
            w_oam_w_next   = 1'b1;
            w_oamaddr_next = r_oamaddr + 8'd1;
          end
        end
        S_WAIT: begin
          w_state_next = r_par ? S_ALIGN : S_READ;
        end
        S_ALIGN: begin
          w_state_next = S_READ;
        end
        S_READ: begin
          // Page is never incremented, so page $FF wraps inside $FF00-$FFFF.
          w_dma_a_next  = {r_page, r_idx};
          w_dma_rd_next = 1'b1;
          w_state_next  = S_WRITE;
        end
        S_WRITE: begin
          // DMA writes relative to OAMADDR but leaves OAMADDR itself untouched.
          w_oam_a_next  = r_oamaddr + r_idx;
          w_oam_d_next  = mem_i;
          w_oam_w_next  = 1'b1;
          w_dma_rd_next = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_halt_next  = 1'b0;
            w_state_next = S_IDLE;
          end else begin
            w_idx_next   = r_idx + 8'd1;
            w_state_next = S_READ;
          end
        end
        default: begin
          w_halt_next   = 1'b0;
          w_dma_rd_next = 1'b0;
          w_state_next  = S_IDLE;
        end
      endcase
    end
  end

  // Datapath registers; reset clears everything, aborting any DMA in flight.
  always_ff @(posedge clock25) begin
    if (reset) begin
      r_halt    <= 1'b0;
      r_dma_a   <= 16'h0000;
      r_dma_rd  <= 1'b0;
      r_oam_a   <= 8'h00;
      r_oam_d   <= 8'h00;
      r_oam_w   <= 1'b0;
      r_oamaddr <= 8'h00;
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
      r_cyc     <= 1'b0;
      r_par     <= 1'b0;
    end else begin
      r_halt    <= w_halt_next;
      r_dma_a   <= w_dma_a_next;
      r_dma_rd  <= w_dma_rd_next;
      r_oam_a   <= w_oam_a_next;
      r_oam_d   <= w_oam_d_next;
      r_oam_w   <= w_oam_w_next;
      r_oamaddr <= w_oamaddr_next;
      r_page    <= w_page_next;
      r_idx     <= w_idx_next;
      r_cyc     <= w_cyc_next;
      r_par     <= w_par_next;
    end
  end

  assign halt      = r_halt;
  assign dma_a     = r_dma_a;
  assign dma_rd    = r_dma_rd;
  assign oam_a     = r_oam_a;
  assign oam_d     = r_oam_d;
  assign oam_w     = r_oam_w;
  assign oamaddr   = r_oamaddr;
  assign dbg_state = r_state;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side writer into sprite attribute memory (OAM). It is the writing end of the OAM port that the PPU's sprite evaluator reads.
- Decodes CPU writes to OAMADDR ($2003), OAMDATA ($2004) and OAMDMA ($4014).
- On a $4014 write it halts the CPU and copies 256 bytes from CPU page $XX00–$XXFF into OAM, using NES-accurate 513/514-cycle timing.
- Sits between the CPU bus, the main memory read port and the OAM write port. Advances only on ce_cpu.

Parameters:
- DMA_REG, 16'h4014, CPU address of the DMA trigger register.
- OAM_SIZE, 256, number of OAM bytes copied per DMA (index width 8).

Ports:
- clock25  in  1  system clock (25 MHz)
- reset    in  1  synchronous, active-high reset
- ce_cpu   in  1  CPU clock-enable, one clock25 pulse per CPU cycle
- cpu_a    in  16  CPU address
- cpu_o    in  8  CPU write data
- cpu_w    in  1  CPU write strobe, qualified by ce_cpu
- mem_i    in  8  main memory read data; valid at the ce_cpu tick after dma_a is presented
- halt     out 1  stalls the CPU while DMA owns the bus
- dma_a    out 16  memory read address during DMA
- dma_rd   out 1  DMA read request, high in READ state
- oam_a    out 8  OAM write address
- oam_d    out 8  OAM write data
- oam_w    out 1  OAM write strobe, one clock25 pulse
- oamaddr  out 8  current OAMADDR register value

Behaviour:
- Reset: state=IDLE, halt=0, dma_rd=0, dma_a=0, oam_a=0, oam_d=0, oam_w=0, oamaddr=0, page=0, idx=0, cyc=0.
- Reset mid-DMA aborts immediately with the same values. No further OAM writes occur.
- oam_w defaults to 0 every clock. It goes high for exactly one clock25 cycle per write.
- cyc toggles on every ce_cpu tick. It is the CPU cycle parity.
- All register decode and state transitions happen only on clocks where ce_cpu=1.
- Register decode applies when cpu_w=1, in IDLE only.
  - $2003: cpu_a[15:13]=3'b001 and cpu_a[2:0]=3. Sets oamaddr<=cpu_o.
  - $2004: cpu_a[15:13]=3'b001 and cpu_a[2:0]=4. Sets oam_a<=oamaddr, oam_d<=cpu_o, oam_w<=1, oamaddr<=oamaddr+1 (wraps 255->0).
  - DMA_REG: sets page<=cpu_o, idx<=0, par<=cyc (value before toggle at this tick), state<=WAIT, halt<=1.
- States:
  - IDLE: halt=0. Decode as above.
  - WAIT: next tick goes to ALIGN if par=1, else READ.
  - ALIGN: one dummy tick, then READ.
  - READ: dma_a<={page, idx}, dma_rd=1. Next tick goes to WRITE.
  - WRITE: oam_a<=oamaddr+idx (8-bit wrap), oam_d<=mem_i, oam_w<=1, dma_rd<=0. If idx=255 go to IDLE and set halt<=0; else idx<=idx+1 and go to READ.
- Halted tick count, counting the ticks after the trigger tick while halt=1:
  - 513 when par=0.
  - 514 when par=1.
- halt rises on the clock after the trigger tick and falls on the clock after the final WRITE tick.
- oamaddr is not modified by DMA. A full 256-byte copy wraps back to the start address.
- Writes to $2003/$2004/$4014 while not in IDLE are ignored. A second $4014 during DMA is ignored.
- Page $FF wraps dma_a at $FFFF only. There is no carry into the page.
- Simultaneous ce_cpu and reset: reset wins.

Test Plan:
1. Reset, then write $2003=$10 and $2004=$AB, $CD -> OAM[$10]=$AB, OAM[$11]=$CD; oamaddr=$12; two single-clock oam_w pulses.
2. Fill RAM $0200–$02FF with value=i^$5A, oamaddr=0, trigger $4014=$02 at even cyc -> halt high for exactly 513 ce_cpu ticks; OAM[i]=i^$5A for all i; 256 oam_w pulses; oamaddr stays 0.
3. Same as scenario 2 but triggered at odd cyc -> halt for exactly 514 ticks; identical OAM contents.
4. oamaddr=$FE, DMA page $03 -> OAM[$FE]=mem[$0300], OAM[$FF]=mem[$0301], OAM[$00]=mem[$0302]; oamaddr ends at $FE.
5. Assert reset after 100 DMA bytes -> halt=0 the next clock; no oam_w afterwards; a subsequent $4014 write starts a fresh 513/514-tick DMA.
6. Write $4014 and $2004 during an active DMA -> both ignored; exactly 256 OAM writes occur; halt duration unchanged.
